// File: rtl/character_sprite_renderer_pkg.sv
// Shared constants for the character sprite path: display ids (common with the
// display state controller), sprite geometry defaults and the transparent colour key.
package character_sprite_renderer_pkg;

    localparam int ID_WIDTH = 3;

    localparam logic [ID_WIDTH-1:0] IDLE_DIS_1      = 3'd0;
    localparam logic [ID_WIDTH-1:0] IDLE_DIS_2      = 3'd1;
    localparam logic [ID_WIDTH-1:0] WALK_DIS_1      = 3'd2;
    localparam logic [ID_WIDTH-1:0] WALK_DIS_2      = 3'd3;
    localparam logic [ID_WIDTH-1:0] JUMP_DIS        = 3'd4;
    localparam logic [ID_WIDTH-1:0] HURT_DIS        = 3'd5;
    localparam logic [ID_WIDTH-1:0] SAFE_GROUND_DIS = 3'd6;

    localparam int SPRITE_W_DEFAULT    = 32;
    localparam int SPRITE_H_DEFAULT    = 32;
    localparam int NUM_SPRITES_DEFAULT = 7;

    localparam logic [11:0] TRANSPARENT_COLOR_DEFAULT = 12'hF0F;

    // Out-of-range ids fall back to the first idle sprite.
    function automatic logic [ID_WIDTH-1:0] sanitize_id(input logic [ID_WIDTH-1:0] id,
                                                        input int num_sprites);
        return (int'(id) < num_sprites) ? id : IDLE_DIS_1;
    endfunction

endpackage

// File: rtl/character_sprite_renderer_sprite_hit_test.sv
// Stage 0 of the sprite pipeline: signed box test of the scan pixel against the
// sprite origin, producing registered hit/valid flags and sprite-local coordinates.
module sprite_hit_test #(
    parameter int POS_WIDTH = 11,
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 32
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          pixel_valid,
    input  logic [POS_WIDTH-2:0]          pixel_x,
    input  logic [POS_WIDTH-2:0]          pixel_y,
    input  logic [POS_WIDTH-1:0]          pos_x,
    input  logic [POS_WIDTH-1:0]          pos_y,
    output logic                          valid_r,
    output logic                          hit_r,
    output logic [$clog2(SPRITE_W)-1:0]   local_x_r,
    output logic [$clog2(SPRITE_H)-1:0]   local_y_r
);

    localparam int DW  = POS_WIDTH + 1;
    localparam int LXW = $clog2(SPRITE_W);
    localparam int LYW = $clog2(SPRITE_H);
    localparam logic [DW-1:0] W_LIMIT = DW'(SPRITE_W);
    localparam logic [DW-1:0] H_LIMIT = DW'(SPRITE_H);

    logic [DW-1:0] dx_s;
    logic [DW-1:0] dy_s;
    logic          hit_s;

    // Differences are one bit wider than the position so off-screen origins never wrap.
    always_comb begin
        dx_s  = {2'b00, pixel_x} - {pos_x[POS_WIDTH-1], pos_x};
        dy_s  = {2'b00, pixel_y} - {pos_y[POS_WIDTH-1], pos_y};
        hit_s = !dx_s[DW-1] && (dx_s < W_LIMIT) && !dy_s[DW-1] && (dy_s < H_LIMIT);
    end

    // Stage 0 register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            valid_r   <= 1'b0;
            hit_r     <= 1'b0;
            local_x_r <= '0;
            local_y_r <= '0;
        end else begin
            valid_r <= pixel_valid;
            hit_r   <= pixel_valid && hit_s;
            if (pixel_valid) begin
                local_x_r <= dx_s[LXW-1:0];
                local_y_r <= dy_s[LYW-1:0];
            end
        end
    end

endmodule

// File: rtl/character_sprite_renderer.sv
// Frame-latched character sprite renderer: maps scan pixels to sprite ROM reads and
// emits colour plus an opaque flag 3 cycles later. Optional macro: CHAR_SPRITE_MIRROR_EN.
module character_sprite_renderer
    import character_sprite_renderer_pkg::*;
#(
    parameter int                     POS_WIDTH         = 11,
    parameter int                     SPRITE_W          = SPRITE_W_DEFAULT,
    parameter int                     SPRITE_H          = SPRITE_H_DEFAULT,
    parameter int                     NUM_SPRITES       = NUM_SPRITES_DEFAULT,
    parameter int                     COLOR_WIDTH       = 12,
    parameter logic [COLOR_WIDTH-1:0] TRANSPARENT_COLOR = TRANSPARENT_COLOR_DEFAULT,
    parameter int                     ROM_ADDR_WIDTH    = ID_WIDTH + $clog2(SPRITE_H) + $clog2(SPRITE_W)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      frame_start,
    input  logic [ID_WIDTH-1:0]       char_display_id,
    input  logic                      char_face_left,
    input  logic [POS_WIDTH-1:0]      char_pos_x,
    input  logic [POS_WIDTH-1:0]      char_pos_y,
    input  logic                      pixel_valid,
    input  logic [POS_WIDTH-2:0]      pixel_x,
    input  logic [POS_WIDTH-2:0]      pixel_y,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [COLOR_WIDTH-1:0]    rom_data,
    output logic                      pix_out_valid,
    output logic [COLOR_WIDTH-1:0]    pix_out_color,
    output logic                      pix_out_opaque
);

    localparam int LXW = $clog2(SPRITE_W);
    localparam int LYW = $clog2(SPRITE_H);

    logic [ID_WIDTH-1:0]  shadow_id_r;
    logic                 shadow_face_r;
    logic [POS_WIDTH-1:0] shadow_x_r;
    logic [POS_WIDTH-1:0] shadow_y_r;

    logic                 s0_valid_s;
    logic                 s0_hit_s;
    logic [LXW-1:0]       s0_lx_s;
    logic [LYW-1:0]       s0_ly_s;
    logic [ID_WIDTH-1:0]  s0_id_r;
    logic                 s0_face_r;
    logic [LXW-1:0]       lx_sel_s;

    logic                 s1_valid_r;
    logic                 s1_hit_r;
    logic                 s2_valid_r;
    logic                 s2_hit_r;
    logic                 opaque_s;

    // Frame latch: pixels in the frame_start cycle still see the old values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow_id_r   <= IDLE_DIS_1;
            shadow_face_r <= 1'b0;
            shadow_x_r    <= '0;
            shadow_y_r    <= '0;
        end else if (frame_start) begin
            shadow_id_r   <= sanitize_id(char_display_id, NUM_SPRITES);
`ifdef CHAR_SPRITE_MIRROR_EN
            shadow_face_r <= char_face_left;
`else
            shadow_face_r <= 1'b0;
`endif
            shadow_x_r    <= char_pos_x;
            shadow_y_r    <= char_pos_y;
        end
    end

`ifndef CHAR_SPRITE_MIRROR_EN
    logic unused_face_s;
    assign unused_face_s = char_face_left;
`endif

    sprite_hit_test #(
        .POS_WIDTH (POS_WIDTH),
        .SPRITE_W  (SPRITE_W),
        .SPRITE_H  (SPRITE_H)
    ) u_hit_test (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pos_x       (shadow_x_r),
        .pos_y       (shadow_y_r),
        .valid_r     (s0_valid_s),
        .hit_r       (s0_hit_s),
        .local_x_r   (s0_lx_s),
        .local_y_r   (s0_ly_s)
    );

    // Sprite id and facing travel with the pixel so a later frame_start cannot split it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s0_id_r   <= '0;
            s0_face_r <= 1'b0;
        end else if (pixel_valid) begin
            s0_id_r   <= shadow_id_r;
            s0_face_r <= shadow_face_r;
        end
    end

`ifdef CHAR_SPRITE_MIRROR_EN
    localparam logic [LXW-1:0] LX_MAX = LXW'(SPRITE_W - 1);

    // Left-facing sprites read the ROM row right to left.
    always_comb begin
        if (s0_face_r) begin
            lx_sel_s = LX_MAX - s0_lx_s;
        end else begin
            lx_sel_s = s0_lx_s;
        end
    end
`else
    logic unused_s0_face_s;
    assign unused_s0_face_s = s0_face_r;
    assign lx_sel_s         = s0_lx_s;
`endif

    // Stages 1-2: ROM address issue, then hold hit/valid while the ROM answers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rom_addr   <= '0;
            s1_valid_r <= 1'b0;
            s1_hit_r   <= 1'b0;
            s2_valid_r <= 1'b0;
            s2_hit_r   <= 1'b0;
        end else begin
            if (s0_hit_s) begin
                rom_addr <= {s0_id_r, s0_ly_s, lx_sel_s};
            end
            s1_valid_r <= s0_valid_s;
            s1_hit_r   <= s0_hit_s;
            s2_valid_r <= s1_valid_r;
            s2_hit_r   <= s1_hit_r;
        end
    end

    assign opaque_s = s2_hit_r && (rom_data != TRANSPARENT_COLOR);

    // Stage 3 output register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_out_valid  <= 1'b0;
            pix_out_opaque <= 1'b0;
            pix_out_color  <= '0;
        end else begin
            pix_out_valid  <= s2_valid_r;
            pix_out_opaque <= opaque_s;
            pix_out_color  <= opaque_s ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_character_sprite_renderer.sv
// Self-checking bench for character_sprite_renderer: directed scenarios followed by
// randomized frames, checked against a per-pixel arithmetic model of the sprite rules.
module tb_character_sprite_renderer;

    localparam int PW = 11;
    localparam int CW = 12;
    localparam int AW = 13;
`ifdef CHAR_SPRITE_MIRROR_EN
    localparam logic [AW-1:0] TP2_ADDR = 13'h0C1F;
`else
    localparam logic [AW-1:0] TP2_ADDR = 13'h0C00;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic          frame_start = 1'b0;
    logic [2:0]    char_display_id = 3'd0;
    logic          char_face_left = 1'b0;
    logic [PW-1:0] char_pos_x = '0;
    logic [PW-1:0] char_pos_y = '0;
    logic          pixel_valid = 1'b0;
    logic [PW-2:0] pixel_x = '0;
    logic [PW-2:0] pixel_y = '0;
    logic [AW-1:0] rom_addr;
    logic [CW-1:0] rom_data = '0;
    logic          pix_out_valid;
    logic [CW-1:0] pix_out_color;
    logic          pix_out_opaque;

    character_sprite_renderer dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .frame_start     (frame_start),
        .char_display_id (char_display_id),
        .char_face_left  (char_face_left),
        .char_pos_x      (char_pos_x),
        .char_pos_y      (char_pos_y),
        .pixel_valid     (pixel_valid),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .pix_out_valid   (pix_out_valid),
        .pix_out_color   (pix_out_color),
        .pix_out_opaque  (pix_out_opaque)
    );

    always #5 sys_clk = ~sys_clk;

    logic [CW-1:0] rom_mem [0:(1<<AW)-1];

    always @(posedge sys_clk) rom_data <= rom_mem[rom_addr];

    typedef struct {
        bit            v;
        bit            h;
        int            addr;
        logic [CW-1:0] col;
        bit            opq;
    } exp_t;

    exp_t hist [4];
    int   sh_id, sh_x, sh_y;
    bit   sh_face;
    int   exp_addr;
    int   in_id, in_x, in_y;
    bit   in_face;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            hist[i].v = 1'b0; hist[i].h = 1'b0; hist[i].addr = 0;
            hist[i].col = '0; hist[i].opq = 1'b0;
        end
        sh_id = 0; sh_x = 0; sh_y = 0; sh_face = 1'b0; exp_addr = 0;
    endtask

    // One clock: drive inputs, model the sampling edge, check outputs on the falling edge.
    task automatic cycle(input bit fs, input bit pv, input int px, input int py);
        exp_t e;
        int   dx, dy, lx;
        frame_start     = fs;
        pixel_valid     = pv;
        pixel_x         = (PW-1)'(px);
        pixel_y         = (PW-1)'(py);
        char_display_id = 3'(in_id);
        char_face_left  = in_face;
        char_pos_x      = PW'(in_x);
        char_pos_y      = PW'(in_y);
        @(posedge sys_clk);
        dx = px - sh_x;
        dy = py - sh_y;
        e.v = pv;
        e.h = pv && dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
        e.addr = 0;
        e.col = '0;
        if (e.h) begin
            lx = dx;
`ifdef CHAR_SPRITE_MIRROR_EN
            if (sh_face) lx = 31 - dx;
`endif
            e.addr = sh_id * 1024 + dy * 32 + lx;
            e.col  = rom_mem[e.addr];
        end
        e.opq = e.h && (e.col != 12'hF0F);
        if (!e.opq) e.col = '0;
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = e;
        if (hist[1].h) exp_addr = hist[1].addr;
        if (fs) begin
            sh_id = (in_id < 7) ? in_id : 0;
            sh_face = in_face; sh_x = in_x; sh_y = in_y;
        end
        @(negedge sys_clk);
        check("out_valid", 32'(pix_out_valid), 32'(hist[3].v));
        check("out_opaque", 32'(pix_out_opaque), 32'(hist[3].opq));
        check("out_color", 32'(pix_out_color), 32'(hist[3].col));
        check("rom_addr", 32'(rom_addr), 32'(exp_addr));
    endtask

    task automatic do_reset();
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        sys_rst_n   = 1'b0;
        #1;
        check("rst_valid", 32'(pix_out_valid), 32'd0);
        check("rst_opaque", 32'(pix_out_opaque), 32'd0);
        check("rst_color", 32'(pix_out_color), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        @(posedge sys_clk);
        #1 check("rst_valid_edge", 32'(pix_out_valid), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_model();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            rom_mem[a] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom_range(0, 4095));
        end
        in_id = 0; in_x = 0; in_y = 0; in_face = 1'b0;
        clear_model();
        #2;
        do_reset();

        // id 3 at (100,50), facing right
        in_id = 3; in_x = 100; in_y = 50; in_face = 1'b0;
        cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 100, 50);
        cycle(1'b0, 1'b0, 0, 0);
        check("tp1_addr", 32'(rom_addr), 32'h0C00);
        cycle(1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 0, 0);
        check("tp1_valid", 32'(pix_out_valid), 32'd1);

        // same sprite facing left
        in_face = 1'b1;
        cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 100, 50);
        cycle(1'b0, 1'b0, 0, 0);
        check("tp2_addr", 32'(rom_addr), 32'(TP2_ADDR));
        cycle(1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 0, 0);

        // partly off-screen origin, colour key and opaque colour
        in_face = 1'b0; in_x = -10; in_y = -5;
        rom_mem[13'h0CAA] = 12'h123;
        rom_mem[13'h0FFF] = 12'hF0F;
        cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 0, 0);
        cycle(1'b0, 1'b1, 21, 26);
        check("tp3_addr_a", 32'(rom_addr), 32'h0CAA);
        cycle(1'b0, 1'b1, 22, 0);
        check("tp3_addr_b", 32'(rom_addr), 32'h0FFF);
        cycle(1'b0, 1'b0, 0, 0);
        check("tp3_addr_hold", 32'(rom_addr), 32'h0FFF);
        check("tp3_opaque_a", 32'(pix_out_opaque), 32'd1);
        check("tp3_color_a", 32'(pix_out_color), 32'h123);
        cycle(1'b0, 1'b0, 0, 0);
        check("tp3_opaque_key", 32'(pix_out_opaque), 32'd0);
        check("tp3_color_key", 32'(pix_out_color), 32'd0);
        cycle(1'b0, 1'b0, 0, 0);
        check("tp3_valid_miss", 32'(pix_out_valid), 32'd1);
        check("tp3_opaque_miss", 32'(pix_out_opaque), 32'd0);

        // inputs ignored between frame_start pulses; same-cycle pixel uses old id
        in_id = 1; in_x = 0; in_y = 0;
        cycle(1'b1, 1'b0, 0, 0);
        in_id = 5;
        cycle(1'b0, 1'b1, 3, 4);
        cycle(1'b0, 1'b0, 0, 0);
        check("tp5_ignore", 32'(rom_addr), 32'h0483);
        cycle(1'b1, 1'b1, 3, 4);
        cycle(1'b0, 1'b1, 3, 4);
        check("tp5_same_cycle", 32'(rom_addr), 32'h0483);
        cycle(1'b0, 1'b0, 0, 0);
        check("tp5_next", 32'(rom_addr), 32'h1483);

        // id 7 sanitised to 0
        in_id = 7;
        cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 3, 4);
        cycle(1'b0, 1'b0, 0, 0);
        check("tp6_sanitise", 32'(rom_addr), 32'h0083);

        // reset with pixels in flight
        cycle(1'b0, 1'b1, 3, 4);
        cycle(1'b0, 1'b1, 5, 5);
        do_reset();
        cycle(1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b1, 5, 5);
        cycle(1'b0, 1'b0, 0, 0);
        check("tp7_shadow_reset", 32'(rom_addr), 32'h00A5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 0);

        // randomized frames
        for (int n = 0; n < 3000; n++) begin
            bit fs;
            bit pv;
            int px, py;
            fs = ($urandom_range(0, 39) == 0);
            if (fs || $urandom_range(0, 7) == 0) begin
                in_id   = int'($urandom_range(0, 7));
                in_face = 1'($urandom_range(0, 1));
                in_x    = int'($urandom_range(0, 1083)) - 60;
                in_y    = int'($urandom_range(0, 859)) - 60;
            end
            pv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                px = int'($urandom_range(0, 1023));
                py = int'($urandom_range(0, 1023));
            end else begin
                px = sh_x + int'($urandom_range(0, 43)) - 6;
                py = sh_y + int'($urandom_range(0, 43)) - 6;
            end
            if (px < 0) px = 0;
            if (px > 1023) px = 1023;
            if (py < 0) py = 0;
            if (py > 1023) py = 1023;
            cycle(fs, pv, px, py);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/character_sprite_renderer.md
Name: character_sprite_renderer

Overview:
- Consumer of the 3-bit character display id produced by the character display state controller.
- Converts the current display id, character position and facing into a per-pixel sprite colour for the VGA pixel pipeline.
- Frame-latches its inputs so a sprite never changes mid-frame. Drives a synchronous sprite ROM and emits an opaque/transparent flag for the compositor.

Parameters:
- POS_WIDTH, 11, signed width of char_pos_x/y; unsigned width is POS_WIDTH-1 for pixel_x/y.
- SPRITE_W, 32, sprite width in pixels; must be a power of two.
- SPRITE_H, 32, sprite height in pixels; must be a power of two.
- NUM_SPRITES, 7, number of valid display ids (0..6).
- COLOR_WIDTH, 12, RGB444 colour width.
- TRANSPARENT_COLOR, 12'hF0F, colour key treated as transparent.
- ROM_ADDR_WIDTH, 3+log2(SPRITE_H)+log2(SPRITE_W) (13 by default), sprite ROM address width.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- char_display_id  in  3  display id from the display state controller
- char_face_left  in  1  1 = character faces left
- char_pos_x  in  POS_WIDTH  signed top-left x of the sprite box
- char_pos_y  in  POS_WIDTH  signed top-left y of the sprite box
- pixel_valid  in  1  pixel_x/pixel_y valid this cycle
- pixel_x  in  POS_WIDTH-1  current scan x
- pixel_y  in  POS_WIDTH-1  current scan y
- rom_addr  out  ROM_ADDR_WIDTH  sprite ROM address; data returns exactly 1 cycle later
- rom_data  in  COLOR_WIDTH  sprite ROM read data
- pix_out_valid  out  1  output pixel valid
- pix_out_color  out  COLOR_WIDTH  sprite colour; 0 when not opaque
- pix_out_opaque  out  1  1 = sprite pixel covers the background

Behaviour:
- Reset state: all outputs 0. Shadow registers are id 0, face 0, pos (0,0). Pipeline valid bits are 0.
- Frame latch:
  - On a cycle with frame_start=1, the shadow id, face and position load from the inputs at that clock edge.
  - A pixel presented in the same cycle as frame_start uses the pre-update shadow values.
  - Between frame_start pulses the input ports are ignored.
- Id sanitising: a latched id >= NUM_SPRITES is stored as 0.
- Stage 0 (registered on pixel_valid):
  - dx = pixel_x - pos_x and dy = pixel_y - pos_y, computed signed at POS_WIDTH+1 bits.
  - hit = (0 <= dx < SPRITE_W) && (0 <= dy < SPRITE_H).
  - lx = dx[log2W-1:0], ly = dy[log2H-1:0].
- Stage 1: if face=1, lx = SPRITE_W-1-lx. rom_addr = {id, ly, lx} is registered. hit and valid are carried forward.
- Stage 2: ROM data arrives; the aligned hit/valid copy waits one cycle.
- Stage 3 (output register):
  - pix_out_valid = delayed valid.
  - pix_out_opaque = hit && rom_data != TRANSPARENT_COLOR.
  - pix_out_color = opaque ? rom_data : 0.
- Latency and throughput: fixed 3 cycles from pixel_valid to pix_out_valid. Full throughput, one pixel per cycle, no stalls.
- When not hit: rom_addr holds its previous value; output is not opaque.
- Boundaries:
  - Negative pos (partly off-screen left/top): only on-screen pixels hit.
  - pos_x + SPRITE_W beyond the screen: no wrap, since dx is computed wide.
  - dx = SPRITE_W exactly gives miss.
- Reset mid-frame: pipeline flushes immediately and shadow regs return to reset values until the next frame_start.

Optional Feature:
- CHAR_SPRITE_MIRROR_EN
  - Defined: horizontal mirroring by char_face_left as described above.
  - Undefined: the char_face_left port is kept but ignored, the mirror subtractor is removed, and lx is used directly.

Decomposition:
- Shared package: the display-id localparams (IDLE_DIS_1=0 … SAFE_GROUND_DIS=6, shared with the display state controller), TRANSPARENT_COLOR, SPRITE_W/SPRITE_H defaults.
- One natural sub-module: sprite_hit_test (stage-0 signed box test and local coordinate generation).

Test Plan:
- Reset, then frame_start with id=3, pos(100,50), face=0; pixel (100,50) valid -> 3 cycles later rom_addr seen = {3,0,0} = 0x0C00, pix_out_valid=1, opaque per ROM.
- Same setup with face=1 (macro defined); pixel (100,50) -> rom_addr {3,0,31} = 0x0C1F. With the macro undefined -> 0x0C00.
- pos(-10,-5); pixels (0,0) and (21,26) -> hit with local (10,5) and (31,31). Pixel (22,0) -> pix_out_opaque=0, color=0.
- ROM returns 12'hF0F inside the box -> opaque=0, color=0. ROM returns 12'h123 -> opaque=1, color=12'h123.
- Change char_display_id from 1 to 5 mid-frame without frame_start -> addresses keep id 1. Pulse frame_start together with a pixel -> that pixel uses id 1, the next uses id 5.
- Latch id=7 -> addresses use id 0. Assert sys_rst_n=0 with pixels in flight -> pix_out_valid=0 on the next edge and no stale outputs after release.
